ahb_xfer_ctrl: RTL and testbench

AHB-Lite transfer sequencer for the encryption accelerator's slave port. It decodes the AHB address phase and drives the bus-side datapath through its control strobes (`readk_enable`, `read_enable`, `write_enable`, `hresp_error`, `hready_enable`). It also inserts wait states, issues two-cycle ERROR responses, and hands off to the cipher core. It sits between the AHB interconnect and the HWDATA/HRDATA datapath, and owns every sequencing decision that datapath takes.

---
 rtl/ahb_xfer_ctrl_if.sv | 27 ++
 rtl/ahb_xfer_ctrl.sv | 143 ++++++++++++++
 tb/tb_ahb_xfer_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_xfer_ctrl_if.sv
// Bus-side signal bundle for ahb_xfer_ctrl: AHB address-phase inputs, core status
// and the datapath control strobes. The slave modport is the controller's view.
interface ahb_xfer_ctrl_if;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic        HREADY;
   logic        core_busy;
   logic        core_done;
   logic        readk_enable;
   logic        read_enable;
   logic        write_enable;
   logic        hresp_error;
   logic        hready_enable;
   logic        start_core;

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HREADY, core_busy, core_done,
      output readk_enable, read_enable, write_enable, hresp_error, hready_enable, start_core
   );

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HREADY, core_busy, core_done,
      input  readk_enable, read_enable, write_enable, hresp_error, hready_enable, start_core
   );
endinterface

// File: rtl/ahb_xfer_ctrl.sv
// AHB-Lite transfer sequencer for the cipher slave port: wait states, ERROR responses, core start.
// Optional result-stall timeout is compiled in with `define AHB_XFER_CTRL_TIMEOUT_EN.
module ahb_xfer_ctrl #(
   parameter logic [31:0] KEY_ADDR    = 32'h0000_0000,
   parameter logic [31:0] DATA_ADDR   = 32'h0000_0010,
   parameter logic [31:0] RESULT_ADDR = 32'h0000_0020,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter int unsigned TIMEOUT     = 64
) (
   input  logic           clk,
   input  logic           n_rst,
   ahb_xfer_ctrl_if.slave bus
);

   if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("ahb_xfer_ctrl: WAIT_CYCLES must be 1..15");
   end
   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("ahb_xfer_ctrl: TIMEOUT must be 1..255");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_KEY, S_DATA, S_RSLT, S_DONE, S_ERR1, S_ERR2
   } state_e;

   localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

   state_e     state_q, state_d, tgt;
   logic [3:0] cnt_q, cnt_d;
   logic       res_valid_q, res_valid_d, res_clr;
   logic       accept, cnt_last;
   logic       readk_q, read_q, write_q, hresp_q, hready_q, start_q;

`ifdef AHB_XFER_CTRL_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
   logic [7:0] tmo_q, tmo_d;
`endif

   always_comb begin
      accept   = bus.HSEL && bus.HREADY && (bus.HTRANS inside {2'b10, 2'b11});
      cnt_last = (cnt_q == CNT_LAST);

      if (bus.HWRITE && bus.HADDR == KEY_ADDR)                        tgt = S_KEY;
      else if (bus.HWRITE && bus.HADDR == DATA_ADDR && !bus.core_busy) tgt = S_DATA;
      else if (!bus.HWRITE && bus.HADDR == RESULT_ADDR)                tgt = S_RSLT;
      else                                                             tgt = S_ERR1;

      state_d = state_q;
      cnt_d   = cnt_q;
      res_clr = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = tgt;
               res_clr = (tgt == S_DATA);
            end
         end
         S_KEY, S_DATA: begin
            if (cnt_last) begin
               state_d = S_DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_RSLT: begin
            // strobe counting only starts once a result is held
            if (res_valid_q) begin
               if (cnt_last) begin
                  state_d = S_DONE;
                  cnt_d   = '0;
                  res_clr = 1'b1;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         S_DONE: begin
            if (accept) begin
               state_d = tgt;
               res_clr = (tgt == S_DATA);
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ERR1:  state_d = S_ERR2;
         S_ERR2:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

`ifdef AHB_XFER_CTRL_TIMEOUT_EN
      tmo_d = '0;
      if (state_q == S_RSLT && !res_valid_q && !bus.core_done) begin
         if (tmo_q == TMO_LAST) state_d = S_ERR1;
         else                   tmo_d   = tmo_q + 8'd1;
      end
`endif

      // a core_done pulse overrides any simultaneous clear
      if (bus.core_done)  res_valid_d = 1'b1;
      else if (res_clr)   res_valid_d = 1'b0;
      else                res_valid_d = res_valid_q;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         res_valid_q <= 1'b0;
         readk_q     <= 1'b0;
         read_q      <= 1'b0;
         write_q     <= 1'b0;
         hresp_q     <= 1'b0;
         hready_q    <= 1'b0;
         start_q     <= 1'b0;
`ifdef AHB_XFER_CTRL_TIMEOUT_EN
         tmo_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         res_valid_q <= res_valid_d;
         readk_q     <= (state_d == S_KEY);
         read_q      <= (state_d == S_DATA);
         write_q     <= (state_d == S_RSLT) && res_valid_d;
         hresp_q     <= (state_d == S_ERR1) || (state_d == S_ERR2);
         hready_q    <= (state_d == S_DONE) || (state_d == S_ERR2);
         start_q     <= (state_d == S_DONE) && (state_q == S_DATA);
`ifdef AHB_XFER_CTRL_TIMEOUT_EN
         tmo_q       <= tmo_d;
`endif
      end
   end

   assign bus.readk_enable  = readk_q;
   assign bus.read_enable   = read_q;
   assign bus.write_enable  = write_q;
   assign bus.hresp_error   = hresp_q;
   assign bus.hready_enable = hready_q;
   assign bus.start_core    = start_q;

endmodule

// File: tb/tb_ahb_xfer_ctrl.sv
// Self-checking bench for ahb_xfer_ctrl: directed cases plus randomized transfers
// against a transaction-level model of the expected strobe sequences.
module tb_ahb_xfer_ctrl;
   localparam int unsigned WAITC = 2;
   localparam int unsigned TMO   = 8;
   localparam logic [31:0] KA = 32'h0000_0000;
   localparam logic [31:0] DA = 32'h0000_0010;
   localparam logic [31:0] RA = 32'h0000_0020;

   // {readk, read, write, hresp, hready, start}
   localparam logic [5:0] E_IDLE = 6'b000000;
   localparam logic [5:0] E_KEY  = 6'b100000;
   localparam logic [5:0] E_DATA = 6'b010000;
   localparam logic [5:0] E_WR   = 6'b001000;
   localparam logic [5:0] E_ERR1 = 6'b000100;
   localparam logic [5:0] E_ERR2 = 6'b000110;
   localparam logic [5:0] E_DONE = 6'b000010;
   localparam logic [5:0] E_DNS  = 6'b000011;

   typedef enum {K_KEY, K_DATA, K_RSLT, K_ERR} kind_e;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   bit          res_valid_m = 1'b0;
   kind_e       last_kind = K_ERR;

   ahb_xfer_ctrl_if bus ();

   ahb_xfer_ctrl #(
      .KEY_ADDR    (KA),
      .DATA_ADDR   (DA),
      .RESULT_ADDR (RA),
      .WAIT_CYCLES (WAITC),
      .TIMEOUT     (TMO)
   ) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] obs();
      return {bus.readk_enable, bus.read_enable, bus.write_enable,
              bus.hresp_error, bus.hready_enable, bus.start_core};
   endfunction

   function automatic kind_e classify(input logic [31:0] a, input logic w, input logic busy);
      if (w && a == KA)             return K_KEY;
      if (w && a == DA && !busy)    return K_DATA;
      if (!w && a == RA)            return K_RSLT;
      return K_ERR;
   endfunction

   task automatic check(input string tag, input logic [5:0] exp);
      logic [5:0] o;
      o = obs();
      n_cmp++;
      assert (o === exp) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, o, exp);
      end
      n_cmp++;
      assert ($countones(o[5:3]) <= 1) else begin
         n_err++;
         $error("FAIL %s_excl observed=%b expected=at most one strobe", tag, o);
      end
   endtask

   task automatic drop_req();
      bus.HSEL   = 1'b0;
      bus.HTRANS = 2'b00;
      bus.HADDR  = $urandom;
      bus.HWRITE = 1'($urandom);
   endtask

   task automatic idle(input string tag, input int unsigned n, input bit pulse);
      for (int i = 0; i < int'(n); i++) begin
         @(negedge clk);
         check(tag, E_IDLE);
      end
      if (pulse) begin
         bus.core_done = 1'b1;
         @(posedge clk); #1;
         bus.core_done = 1'b0;
         res_valid_m = 1'b1;
      end
   endtask

   task automatic xfer(input string tag, input logic [31:0] a, input logic w,
                       input logic busy, input int unsigned stall);
      kind_e      k;
      logic [5:0] q[$];
      k = classify(a, w, busy);
      bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = a; bus.HWRITE = w;
      bus.core_busy = busy;
      @(posedge clk); #1;
      drop_req();
      bus.core_busy = 1'($urandom);
      case (k)
         K_KEY: begin
            repeat (WAITC) q.push_back(E_KEY);
            q.push_back(E_DONE);
         end
         K_DATA: begin
            res_valid_m = 1'b0;
            repeat (WAITC) q.push_back(E_DATA);
            q.push_back(E_DNS);
         end
         K_RSLT: begin
            if (!res_valid_m) begin
               for (int i = 0; i < int'(stall); i++) begin
                  @(negedge clk);
                  check({tag, "_stall"}, E_IDLE);
               end
               bus.core_done = 1'b1;
               @(posedge clk); #1;
               bus.core_done = 1'b0;
            end
            res_valid_m = 1'b0;
            repeat (WAITC) q.push_back(E_WR);
            q.push_back(E_DONE);
         end
         default: begin
            q.push_back(E_ERR1);
            q.push_back(E_ERR2);
         end
      endcase
      while (q.size() > 0) begin
         @(negedge clk);
         check(tag, q.pop_front());
      end
      last_kind = k;
   endtask

   initial begin
      logic [31:0] a;
      logic        w;
      int unsigned sel;

      bus.HSEL = 1'b0; bus.HADDR = '0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
      bus.HREADY = 1'b1; bus.core_busy = 1'b0; bus.core_done = 1'b0;

      @(negedge clk);
      check("reset_hold", E_IDLE);
      @(negedge clk);
      n_rst = 1'b1;
      idle("after_reset", 2, 1'b0);

      xfer("key_write", KA, 1'b1, 1'b0, 0);
      idle("key_idle", 1, 1'b0);

      xfer("data_write", DA, 1'b1, 1'b0, 0);
      idle("core_wait", 10, 1'b0);
      xfer("result_stall_read", RA, 1'b0, 1'b0, 3);
      idle("rslt_idle", 1, 1'b0);

      xfer("err_read_key", KA, 1'b0, 1'b0, 0);
      idle("err_idle0", 1, 1'b0);
      xfer("err_write_result", RA, 1'b1, 1'b0, 0);
      idle("err_idle1", 1, 1'b0);
      xfer("err_unmapped", 32'h44, 1'b1, 1'b0, 0);
      idle("err_idle2", 1, 1'b0);
      xfer("err_read_data", DA, 1'b0, 1'b0, 0);
      idle("err_idle3", 1, 1'b0);
      xfer("err_busy_write", DA, 1'b1, 1'b1, 0);
      idle("err_idle4", 1, 1'b0);

      xfer("b2b_key_a", KA, 1'b1, 1'b0, 0);
      xfer("b2b_key_b", KA, 1'b1, 1'b0, 0);
      xfer("b2b_data", DA, 1'b1, 1'b0, 0);
      idle("b2b_idle", 2, 1'b1);

      // result already held: no stall expected
      xfer("ready_read", RA, 1'b0, 1'b0, 0);
      idle("ready_idle", 1, 1'b1);
      xfer("data_clears_valid", DA, 1'b1, 1'b0, 0);
      xfer("read_after_clear", RA, 1'b0, 1'b0, 2);
      idle("clr_idle", 1, 1'b0);

      bus.HSEL = 1'b1; bus.HTRANS = 2'b00; bus.HADDR = KA; bus.HWRITE = 1'b1;
      @(negedge clk);
      check("htrans_idle_ignored", E_IDLE);
      bus.HTRANS = 2'b10; bus.HREADY = 1'b0;
      @(negedge clk);
      check("hready_low_ignored", E_IDLE);
      bus.HREADY = 1'b1;
      drop_req();
      idle("ignored_idle", 1, 1'b1);

      bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = KA; bus.HWRITE = 1'b1;
      @(posedge clk); #1;
      drop_req();
      @(negedge clk);
      check("rst_pre_key", E_KEY);
      #2 n_rst = 1'b0;
      #1 check("rst_async_drop", E_IDLE);
      res_valid_m = 1'b0;
      @(negedge clk);
      n_rst = 1'b1;
      idle("rst_released", 1, 1'b0);
      xfer("post_rst_read", RA, 1'b0, 1'b0, 2);
      idle("post_rst_idle", 1, 1'b0);
      xfer("post_rst_key", KA, 1'b1, 1'b0, 0);
      idle("post_rst_idle2", 1, 1'b0);

`ifdef AHB_XFER_CTRL_TIMEOUT_EN
      bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = RA; bus.HWRITE = 1'b0;
      @(posedge clk); #1;
      drop_req();
      repeat (TMO) begin
         @(negedge clk);
         check("tmo_stall", E_IDLE);
      end
      @(negedge clk);
      check("tmo_err1", E_ERR1);
      @(negedge clk);
      check("tmo_err2", E_ERR2);
      idle("tmo_idle", 1, 1'b0);
`endif

      for (int t = 0; t < 60; t++) begin
         sel = $urandom_range(0, 5);
         case (sel)
            0, 1:    a = KA;
            2:       a = DA;
            3, 4:    a = RA;
            default: a = $urandom_range(0, 15) == 0 ? 32'h44 : $urandom;
         endcase
         w = ($urandom_range(0, 4) != 0) ? (a != RA) : ~(a != RA);
         xfer("rand_xfer", a, w, ($urandom_range(0, 3) == 0), $urandom_range(1, 5));
         if (last_kind == K_ERR || $urandom_range(0, 2) != 0)
            idle("rand_gap", $urandom_range(1, 3), ($urandom_range(0, 3) == 0));
      end
      idle("final_idle", 2, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
